mdmc_dma: RTL
=============

# mdmc_dma

Single-channel word-copy engine sitting directly upstream of the MDMC AHB-lite master adapter. It accepts a source address, destination address and word count, then issues strictly non-pipelined read/write request pairs on the `mdmc_*` request interface, buffering one word between each read and its write. It reports busy/done/abort status to the control logic that programs it.

## Interface
Parameters:
- `DWIDTH`, 32: data word width; address stride per word is DWIDTH/8 bytes.
- `LEN_W`, 16: width of the word count and progress counter.

Ports:
- `hclk`  in  1  clock.
- `hreset`  in  1  reset; one clock; reset is synchronous and active-high.
- `start`  in  1  one-cycle pulse; launches a copy. Sampled only in IDLE.
- `abort`  in  1  one-cycle pulse; stops after the current word completes.
- `src_addr`  in  32  byte address of the first source word.
- `dst_addr`  in  32  byte address of the first destination word.
- `len`  in  LEN_W  number of words to copy.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on completion or abort.
- `aborted`  out  1  sticky; set when a copy ends by abort, cleared by the next accepted `start`.
- `words_done`  out  LEN_W  words fully written in the current or last copy.
- `mdmc_rd`  out  1  read request, held until accepted.
- `mdmc_wr`  out  1  write request, held until accepted.
- `mdmc_addr`  out  32  request address.
- `mdmc_wdata`  out  DWIDTH  write data; equals the internal data buffer.
- `mdmc_rdata`  in  DWIDTH  read data from the adapter.
- `mdmc_valid`  in  1  read data valid.
- `mdmc_ready`  in  1  bus ready (wired to `hready` at top level).

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DONE.
- IDLE: on `start`, latch src/dst into pointers and len into `remaining`, clear `words_done` and `aborted`. If len == 0, go to DONE; otherwise go to RD_ADDR.
- RD_ADDR: `mdmc_rd`=1, `mdmc_addr`=src pointer. Go to RD_DATA when `mdmc_ready`=1.
- RD_DATA: no request. When `mdmc_valid`=1, capture `mdmc_rdata` into the buffer and go to WR_ADDR.
- WR_ADDR: `mdmc_wr`=1, `mdmc_addr`=dst pointer, `mdmc_wdata`=buffer. Go to WR_DATA when `mdmc_ready`=1.
- WR_DATA: no request. When `mdmc_ready`=1, the word is done:
  - add DWIDTH/8 to both pointers (mod 2^32, wraps silently);
  - decrement `remaining` and increment `words_done`;
  - go to DONE if `remaining` was 1 or an abort is pending; otherwise go to RD_ADDR.
- DONE: `done`=1 for exactly one cycle; if an abort was pending, set `aborted` and clear the pending flag. Then go to IDLE.
- `abort` in any non-IDLE, non-DONE state sets the pending flag. `abort` in IDLE or DONE is ignored. A read already issued is always followed by its write.
- `start` outside IDLE is ignored. If `start` and `abort` arrive in the same IDLE cycle, `start` wins and `abort` is ignored.
- `mdmc_rd` and `mdmc_wr` are never high together.
- Requests are never pipelined: a new address phase only begins after the previous data phase has completed. This protects the adapter's registered write data against overwrite during a stalled data phase.

## Timing
- Reset values: state IDLE; `busy`, `done`, `aborted`, `mdmc_rd`, `mdmc_wr` = 0; `mdmc_addr`, `mdmc_wdata`, `words_done` = 0.
- All outputs decode from registers; there is no combinational input-to-output path.
- `start` sampled at edge k means `busy`=1 and the first RD_ADDR occur in cycle k+1.
- With `mdmc_ready` held at 1: 4 cycles per word, and `done` is asserted in cycle k+1+4·len. For len == 0, `done` is in cycle k+1.
- Each `mdmc_ready`=0 cycle in an ADDR or DATA state adds one cycle. A missing `mdmc_valid` stalls RD_DATA indefinitely; there is no timeout.
- Reset mid-copy: the next edge forces reset values. The AHB side must be reset in the same cycle.

## Structure
- Shared package `mdmc_pkg`: state enumeration, `MDMC_LEN_W` = 16 default, byte-stride function of DWIDTH.
- Single module with no sub-module. Next-state logic, pointer/counter datapath and the DWIDTH buffer are all flat.

## Test plan
- src=0x100, dst=0x200, len=3, ready always 1, read data A/B/C → writes A@0x200, B@0x204, C@0x208; `done` at k+13; `words_done`=3.
- len=0 → no `mdmc_rd`/`mdmc_wr`; `done` at k+1; `busy` high for exactly one cycle.
- `mdmc_ready` low for 2 cycles during WR_DATA, and `mdmc_valid` delayed 3 cycles → each word stretches by the stall length; data unchanged; no overlapping requests.
- len=5, `abort` during word 2's RD_DATA → word 2 is written; `done` then follows; `aborted`=1; `words_done`=2. The next `start` clears `aborted`.
- `start` pulsed while busy, and `abort` pulsed in IDLE → both ignored; the copy in progress is unaffected.
- src=0xFFFF_FFFC, len=2 → second read address wraps to 0x0000_0000. `hreset` mid-copy → next cycle shows all reset values.

Source files
------------

// File: rtl/mdmc_pkg.sv
// mdmc_pkg: shared definitions for the MDMC word-copy engine.
//   - mdmc_state_t : copy-engine state encoding
//   - MDMC_LEN_W   : default width of word count / progress counter
//   - mdmc_stride  : byte stride per data word for a given data width
package mdmc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_DONE    = 3'd5
  } mdmc_state_t;

  localparam int MDMC_LEN_W = 16;

  function automatic int unsigned mdmc_stride(input int unsigned dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/mdmc_dma.sv
// mdmc_dma: single-channel word-copy engine feeding the MDMC AHB-lite
// master adapter. Each word is a read request/data phase followed by a
// write request/data phase; nothing is ever pipelined.
//
// Ports:
//   hclk, hreset          clock, synchronous active-high reset
//   start, abort          one-cycle control pulses
//   src_addr, dst_addr    byte addresses of the first source/destination word
//   len                   number of words to copy
//   busy, done, aborted   status (done is a one-cycle pulse, aborted sticky)
//   words_done            words fully written in the current or last copy
//   mdmc_rd, mdmc_wr      request strobes, held until mdmc_ready
//   mdmc_addr, mdmc_wdata request address / write data (the word buffer)
//   mdmc_rdata, mdmc_valid read data return
//   mdmc_ready            bus ready from the adapter
//   dbg_state             current FSM state, for observation only
//
// Handshake: a request (mdmc_rd or mdmc_wr) is held until a cycle where
// mdmc_ready is 1; the following data phase completes on mdmc_valid (read)
// or mdmc_ready (write). Only then may the next address phase start.
module mdmc_dma
  import mdmc_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int LEN_W  = MDMC_LEN_W
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_done,
  output logic              mdmc_rd,
  output logic              mdmc_wr,
  output logic [31:0]       mdmc_addr,
  output logic [DWIDTH-1:0] mdmc_wdata,
  input  logic [DWIDTH-1:0] mdmc_rdata,
  input  logic              mdmc_valid,
  input  logic              mdmc_ready,
  output logic [2:0]        dbg_state
);

  localparam logic [31:0] STRIDE = 32'(mdmc_stride(DWIDTH));

  mdmc_state_t      r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_rem;
  logic             r_abort_pend;

  // An abort arriving in the same cycle as the final write completion
  // still counts, so the copy ends after this word.
  logic w_abort_now;
  assign w_abort_now = r_abort_pend | abort;

  assign dbg_state = r_state;

  // mdmc_wdata doubles as the one-word buffer between read and write.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state      <= ST_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_rem        <= '0;
      r_abort_pend <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      words_done   <= '0;
      mdmc_rd      <= 1'b0;
      mdmc_wr      <= 1'b0;
      mdmc_addr    <= '0;
      mdmc_wdata   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_src        <= src_addr;
            r_dst        <= dst_addr;
            r_rem        <= len;
            r_abort_pend <= 1'b0;
            words_done   <= '0;
            aborted      <= 1'b0;
            busy         <= 1'b1;
            if (len == '0) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
            end else begin
              r_state   <= ST_RD_ADDR;
              mdmc_rd   <= 1'b1;
              mdmc_addr <= src_addr;
            end
          end
        end
        ST_RD_ADDR: begin
          if (abort) r_abort_pend <= 1'b1;
          if (mdmc_ready) begin
            mdmc_rd <= 1'b0;
            r_state <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (abort) r_abort_pend <= 1'b1;
          if (mdmc_valid) begin
            mdmc_wdata <= mdmc_rdata;
            mdmc_wr    <= 1'b1;
            mdmc_addr  <= r_dst;
            r_state    <= ST_WR_ADDR;
          end
        end
        ST_WR_ADDR: begin
          if (abort) r_abort_pend <= 1'b1;
          if (mdmc_ready) begin
            mdmc_wr <= 1'b0;
            r_state <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (mdmc_ready) begin
            r_src      <= r_src + STRIDE;
            r_dst      <= r_dst + STRIDE;
            r_rem      <= r_rem - 1'b1;
            words_done <= words_done + 1'b1;
            if (r_rem == LEN_W'(1) || w_abort_now) begin
              r_abort_pend <= w_abort_now;
              r_state      <= ST_DONE;
              done         <= 1'b1;
            end else begin
              r_state   <= ST_RD_ADDR;
              mdmc_rd   <= 1'b1;
              mdmc_addr <= r_src + STRIDE;
            end
          end else if (abort) begin
            r_abort_pend <= 1'b1;
          end
        end
        ST_DONE: begin
          if (r_abort_pend) aborted <= 1'b1;
          r_abort_pend <= 1'b0;
          busy         <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          mdmc_rd <= 1'b0;
          mdmc_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule
